// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding, the default operand width and a constant clog2.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_fsub.sv
// Mux-only full subtractor cell (x - y - bin), plus the 2:1 mux primitive it is built from.
// Purely combinational; inversions come from muxes with constant data inputs.
module mux_2x1 (
  input  logic i_sel,
  input  logic i_d0,
  input  logic i_d1,
  output logic o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

module full_subtractor_mux (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic w_ny;
  logic w_xy;
  logic w_nxy;

  mux_2x1 u_not_y   (.i_sel(y),    .i_d0(1'b1), .i_d1(1'b0),  .o_y(w_ny));
  mux_2x1 u_xor_xy  (.i_sel(x),    .i_d0(y),    .i_d1(w_ny),  .o_y(w_xy));
  mux_2x1 u_not_xy  (.i_sel(w_xy), .i_d0(1'b1), .i_d1(1'b0),  .o_y(w_nxy));
  mux_2x1 u_diff    (.i_sel(bin),  .i_d0(w_xy), .i_d1(w_nxy), .o_y(d));
  // When x != y the borrow is simply y; when they match the incoming borrow propagates.
  mux_2x1 u_borrow  (.i_sel(w_xy), .i_d0(bin),  .i_d1(y),     .o_y(bout));
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned A - B, LSB first, WIDTH+2 cycles per operation with a start/done handshake.
// Optional SERIAL_SUB_SIGNED_OVF_EN adds a two's-complement overflow output (ovf).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  full_subtractor_mux u_cell (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
  assign w_last    = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_br   <= w_bout;
          r_res  <= w_res_nxt;
          // Exit at WIDTH-1 keeps the counter from ever wrapping.
          if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_ovf    <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8), hand-computed expectations.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where ready is back,
  // so a following call starts back-to-back. inject>0 pulses a bogus start in that SHIFT cycle.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input int inject, input logic [7:0] ediff, input logic ebr,
                        input logic eovf);
    int          cycles;
    logic [7:0]  prev;
    logic        stable;
    prev   = diff;
    stable = 1'b1;
    a      = ia;
    b      = ib;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".ready_low"}, {31'd0, ready}, 32'd0);
    cycles = 0;
    while (cycles < 40) begin
      if (cycles == inject && inject > 0) begin
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (done) break;
      if (diff !== prev) stable = 1'b0;
    end
    start = 1'b0;
    check({tag, ".latency"}, cycles, WIDTH);
    check({tag, ".stable"}, {31'd0, stable}, 32'd1);
    check({tag, ".diff"}, {24'd0, diff}, {24'd0, ediff});
    check({tag, ".borrow"}, {31'd0, borrow}, {31'd0, ebr});
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
    if (eovf === 1'bx) $display("note: unexpected X ovf expectation");
`endif
    @(negedge clk);
    check({tag, ".ready_back"}, {31'd0, ready}, 32'd1);
    check({tag, ".one_pulse"}, {31'd0, done}, 32'd0);
    check({tag, ".diff_held"}, {24'd0, diff}, {24'd0, ediff});
  endtask

  initial begin
    int saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst.ready",  {31'd0, ready},  32'd1);
    check("rst.busy",   {31'd0, busy},   32'd0);
    check("rst.done",   {31'd0, done},   32'd0);
    check("rst.diff",   {24'd0, diff},   32'd0);
    check("rst.borrow", {31'd0, borrow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("op5a_23", 8'h5A, 8'h23, 0, 8'h37, 1'b0, 1'b0);
    run_op("op10_20", 8'h10, 8'h20, 0, 8'hF0, 1'b1, 1'b0);
    run_op("op00_01", 8'h00, 8'h01, 0, 8'hFF, 1'b1, 1'b0);
    run_op("op00_00", 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0);
    run_op("opa5_a5", 8'hA5, 8'hA5, 0, 8'h00, 1'b0, 1'b0);
    run_op("op80_01", 8'h80, 8'h01, 0, 8'h7F, 1'b0, 1'b1);
    run_op("op05_03", 8'h05, 8'h03, 0, 8'h02, 1'b0, 1'b0);
    run_op("ignore",  8'h09, 8'h04, 3, 8'h05, 1'b0, 1'b0);

    // Abort mid-operation just after the 4th SHIFT edge.
    a     = 8'h5A;
    b     = 8'h23;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.ready",  {31'd0, ready},  32'd1);
    check("abort.busy",   {31'd0, busy},   32'd0);
    check("abort.done",   {31'd0, done},   32'd0);
    check("abort.diff",   {24'd0, diff},   32'd0);
    check("abort.borrow", {31'd0, borrow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("abort.no_done", saw_done, 0);
    run_op("post_abort", 8'h03, 8'h01, 0, 8'h02, 1'b0, 1'b0);

    run_op("b2b_1", 8'hC8, 8'h37, 0, 8'h91, 1'b0, 1'b0);
    run_op("b2b_2", 8'h7F, 8'h80, 0, 8'hFF, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
